stopwatch_core: RTL and testbench

- Consumer end of the one-cycle tick interface driven by the board clock divider.
- Accumulates incoming tick pulses into an MM:SS BCD time value.
- Start/stop, clear and lap controls are handled by a 3-state FSM.
- Feeds the display driver with four BCD digits plus status flags.

---
 rtl/stopwatch_core.sv | 170 +++++++++++++++++
 tb/tb_stopwatch_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// ============================================================================
// Module      : stopwatch_core
// Description : MM:SS BCD stopwatch fed by divider ticks, with start/stop,
//               clear and lap controls and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_core #(
    parameter int TICKS_PER_COUNT = 1,
    parameter bit WRAP            = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] digits,
    output logic        running,
    output logic        lap_active,
    output logic        overflow,
    output logic        count_pulse
);

    localparam int             c_PW       = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1;
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(TICKS_PER_COUNT - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUNNING = 2'd1;
    localparam logic [1:0] c_PAUSED  = 2'd2;

    logic [1:0]      r_state;
    logic [15:0]     r_count;
    logic [15:0]     r_lap;
    logic [c_PW-1:0] r_pre;
    logic            r_lap_active;
    logic            r_overflow;
    logic            r_count_pulse;
    logic            r_start_q;
    logic            r_clear_q;
    logic            r_lap_q;

    logic            w_start_ev;
    logic            w_clear_ev;
    logic            w_lap_ev;
    logic            w_tick_run;
    logic            w_terminal;
    logic [15:0]     w_count_inc;

    assign w_start_ev = btn_start & ~r_start_q;
    assign w_clear_ev = btn_clear & ~r_clear_q;
    assign w_lap_ev   = btn_lap   & ~r_lap_q;
    assign w_tick_run = (r_state == c_RUNNING) && tick;
    assign w_terminal = (r_count == 16'h5959);

    // BCD ripple increment; 59:59 rolls to 00:00 (terminal case handled separately)
    always_comb begin
        w_count_inc = r_count;
        if (r_count[3:0] != 4'd9) begin
            w_count_inc[3:0] = r_count[3:0] + 4'd1;
        end else begin
            w_count_inc[3:0] = 4'd0;
            if (r_count[7:4] != 4'd5) begin
                w_count_inc[7:4] = r_count[7:4] + 4'd1;
            end else begin
                w_count_inc[7:4] = 4'd0;
                if (r_count[11:8] != 4'd9) begin
                    w_count_inc[11:8] = r_count[11:8] + 4'd1;
                end else begin
                    w_count_inc[11:8] = 4'd0;
                    if (r_count[15:12] != 4'd5) begin
                        w_count_inc[15:12] = r_count[15:12] + 4'd1;
                    end else begin
                        w_count_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_count       <= 16'h0000;
            r_lap         <= 16'h0000;
            r_pre         <= '0;
            r_lap_active  <= 1'b0;
            r_overflow    <= 1'b0;
            r_count_pulse <= 1'b0;
            r_start_q     <= 1'b1;
            r_clear_q     <= 1'b1;
            r_lap_q       <= 1'b1;
        end else begin
            r_start_q     <= btn_start;
            r_clear_q     <= btn_clear;
            r_lap_q       <= btn_lap;
            r_count_pulse <= 1'b0;

            if (w_tick_run) begin
                if (r_pre == c_PRE_MAX) begin
                    r_pre <= '0;
                    if (w_terminal) begin
                        r_overflow <= 1'b1;
                        if (WRAP) begin
                            r_count       <= 16'h0000;
                            r_count_pulse <= 1'b1;
                        end
                    end else begin
                        r_count       <= w_count_inc;
                        r_count_pulse <= 1'b1;
                    end
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end

            // Lap capture reads r_count, so a same-cycle tick is not yet included
            case (r_state)
                c_IDLE: begin
                    if (w_clear_ev) begin
                        r_overflow   <= 1'b0;
                        r_lap_active <= 1'b0;
                    end else if (w_start_ev) begin
                        r_state <= c_RUNNING;
                    end
                end
                c_RUNNING: begin
                    if (w_start_ev) begin
                        r_state <= c_PAUSED;
                    end else if (w_lap_ev) begin
                        if (!r_lap_active) begin
                            r_lap        <= r_count;
                            r_lap_active <= 1'b1;
                        end else begin
                            r_lap_active <= 1'b0;
                        end
                    end
                    if (!WRAP && w_tick_run && (r_pre == c_PRE_MAX) && w_terminal) begin
                        r_state <= c_PAUSED;
                    end
                end
                c_PAUSED: begin
                    if (w_clear_ev) begin
                        r_state      <= c_IDLE;
                        r_count      <= 16'h0000;
                        r_lap        <= 16'h0000;
                        r_pre        <= '0;
                        r_overflow   <= 1'b0;
                        r_lap_active <= 1'b0;
                    end else if (w_start_ev) begin
                        r_state <= c_RUNNING;
                    end else if (w_lap_ev) begin
                        r_lap_active <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign digits      = r_lap_active ? r_lap : r_count;
    assign running     = (r_state == c_RUNNING);
    assign lap_active  = r_lap_active;
    assign overflow    = r_overflow;
    assign count_pulse = r_count_pulse;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_core.sv
// ============================================================================
// Module      : tb_stopwatch_core
// Description : Directed bench for stopwatch_core (wrap, saturate, prescaled).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic btn_start = 1'b0;
    logic btn_clear = 1'b0;
    logic btn_lap = 1'b0;

    logic [15:0] w_dig, s_dig, p_dig;
    logic        w_run, s_run, p_run;
    logic        w_lap, s_lap, p_lap;
    logic        w_ovf, s_ovf, p_ovf;
    logic        w_cp,  s_cp,  p_cp;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    always #5 clk = ~clk;

    stopwatch_core #(.TICKS_PER_COUNT(1), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_lap(btn_lap), .digits(w_dig), .running(w_run), .lap_active(w_lap),
        .overflow(w_ovf), .count_pulse(w_cp));

    stopwatch_core #(.TICKS_PER_COUNT(1), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_lap(btn_lap), .digits(s_dig), .running(s_run), .lap_active(s_lap),
        .overflow(s_ovf), .count_pulse(s_cp));

    stopwatch_core #(.TICKS_PER_COUNT(10), .WRAP(1'b1)) u_pre (
        .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
        .btn_lap(btn_lap), .digits(p_dig), .running(p_run), .lap_active(p_lap),
        .overflow(p_ovf), .count_pulse(p_cp));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs set before cyc() are sampled at that edge; outputs are read 1 time unit later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0;
        btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            if (w_cp) n_pulses++;
        end
        tick = 1'b0;
    endtask

    task automatic press_start();
        btn_start = 1'b1; cyc(); btn_start = 1'b0;
    endtask

    task automatic press_clear();
        btn_clear = 1'b1; cyc(); btn_clear = 1'b0;
    endtask

    task automatic press_lap();
        btn_lap = 1'b1; cyc(); btn_lap = 1'b0;
    endtask

    initial begin
        // Reset values
        cyc(); cyc();
        check("rst_digits", {16'h0, w_dig}, 32'h0000);
        check("rst_flags", {28'h0, w_run, w_lap, w_ovf, w_cp}, 32'h0);
        rst = 1'b0;
        cyc();

        // 75 ticks -> 01:15
        press_start();
        check("start_running", {31'h0, w_run}, 32'h1);
        n_pulses = 0;
        do_ticks(75);
        check("run75_digits", {16'h0, w_dig}, 32'h0115);
        check("run75_running", {31'h0, w_run}, 32'h1);
        check("run75_pulses", n_pulses, 75);
        check("run75_sat_digits", {16'h0, s_dig}, 32'h0115);
        check("run75_pre_digits", {16'h0, p_dig}, 32'h0007);

        // Lap freeze and release
        do_reset();
        press_start();
        do_ticks(9);
        press_lap();
        check("lap_set_flag", {31'h0, w_lap}, 32'h1);
        do_ticks(5);
        check("lap_frozen_digits", {16'h0, w_dig}, 32'h0009);
        check("lap_frozen_flag", {31'h0, w_lap}, 32'h1);
        press_lap();
        check("lap_rel_digits", {16'h0, w_dig}, 32'h0014);
        check("lap_rel_flag", {31'h0, w_lap}, 32'h0);

        // Tick plus start in RUNNING counts then pauses; clear from PAUSED
        do_reset();
        press_start();
        do_ticks(3);
        btn_start = 1'b1; tick = 1'b1;
        cyc();
        btn_start = 1'b0; tick = 1'b0;
        check("tickstop_digits", {16'h0, w_dig}, 32'h0004);
        check("tickstop_running", {31'h0, w_run}, 32'h0);
        do_ticks(2);
        check("paused_hold", {16'h0, w_dig}, 32'h0004);
        press_clear();
        check("clear_digits", {16'h0, w_dig}, 32'h0000);
        do_ticks(1);
        check("idle_no_count", {16'h0, w_dig}, 32'h0000);
        press_start();
        do_ticks(2);
        press_clear();
        check("clear_run_digits", {16'h0, w_dig}, 32'h0002);
        check("clear_run_running", {31'h0, w_run}, 32'h1);

        // Overflow: wrap vs saturate
        do_reset();
        press_start();
        do_ticks(3599);
        check("pre_ovf_wrap", {16'h0, w_dig}, 32'h5959);
        check("pre_ovf_sat", {16'h0, s_dig}, 32'h5959);
        check("pre_ovf_flag", {31'h0, w_ovf}, 32'h0);
        do_ticks(1);
        check("wrap_digits", {16'h0, w_dig}, 32'h0000);
        check("wrap_flags", {29'h0, w_run, w_ovf, w_cp}, 32'h7);
        check("sat_digits", {16'h0, s_dig}, 32'h5959);
        check("sat_flags", {29'h0, s_run, s_ovf, s_cp}, 32'h2);
        do_ticks(1);
        check("wrap_after", {16'h0, w_dig}, 32'h0001);
        check("sat_after", {16'h0, s_dig}, 32'h5959);
        press_clear();
        check("sat_clear", {15'h0, s_dig, s_ovf}, 32'h0);
        check("wrap_clear_ignored", {30'h0, w_run, w_ovf}, 32'h3);

        // Prescaler held across pause
        do_reset();
        press_start();
        do_ticks(25);
        check("pre25_digits", {16'h0, p_dig}, 32'h0002);
        press_start();
        check("pre_paused", {31'h0, p_run}, 32'h0);
        do_ticks(7);
        press_start();
        do_ticks(4);
        check("pre_resume4", {16'h0, p_dig}, 32'h0002);
        do_ticks(1);
        check("pre_resume5", {16'h0, p_dig}, 32'h0003);

        // Button held through reset makes no event
        rst = 1'b1; btn_start = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        check("held_start_idle", {31'h0, w_run}, 32'h0);
        btn_start = 1'b0;
        cyc();

        // Async reset mid-count at 12:34
        press_start();
        do_ticks(754);
        check("pre_reset_digits", {16'h0, w_dig}, 32'h1234);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_digits", {16'h0, w_dig}, 32'h0000);
        check("async_rst_flags", {28'h0, w_run, w_lap, w_ovf, w_cp}, 32'h0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
